// File: rtl/fifo_flag_ctrl_pkg.sv
// Shared constants and helpers for the FIFO flag controller: depth derivation,
// default flag thresholds and direction-flag event classification.
package fifo_flag_ctrl_pkg;

  localparam int unsigned DefAddrWidth   = 4;
  localparam int unsigned DefAfullLevel  = 12;
  localparam int unsigned DefAemptyLevel = 2;

  // Effect of one cycle's count change on the downstream direction flag flop
  typedef enum logic [1:0] {
    DirHold,
    DirSet,
    DirClr
  } dir_evt_e;

  function automatic int unsigned fifo_depth(int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Crossing the half-full boundary upwards sets the flag, downwards clears it
  function automatic dir_evt_e dir_event(int unsigned cur, int unsigned nxt,
                                         int unsigned depth);
    if ((cur == depth / 2 - 1) && (nxt == depth / 2)) return DirSet;
    if ((cur == depth / 2) && (nxt == depth / 2 - 1)) return DirClr;
    return DirHold;
  endfunction

endpackage

// File: rtl/fifo_flag_ctrl_if.sv
// Request/enable/status bundle between the FIFO flag controller and its users.
interface fifo_flag_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = fifo_flag_ctrl_pkg::DefAddrWidth
) ();

  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] wr_adr;
  logic [ADDR_WIDTH-1:0] rd_adr;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  dir_set;
  logic                  dir_clr;

  // Producer/consumer side
  modport master (
    output wr_req, rd_req,
    input  wr_en, rd_en, wr_adr, rd_adr, count,
    input  full, empty, almost_full, almost_empty, dir_set, dir_clr
  );

  // Controller side
  modport slave (
    input  wr_req, rd_req,
    output wr_en, rd_en, wr_adr, rd_adr, count,
    output full, empty, almost_full, almost_empty, dir_set, dir_clr
  );

endinterface

// File: rtl/fifo_ptr.sv
// Binary FIFO pointer one bit wider than the RAM address; wraps naturally.
module fifo_ptr #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clock,
  input  logic             sclr,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] ptr_q;

  // Advance by one per accepted access, rolling over from all-ones to zero
  always_ff @(posedge clock) begin
    if (sclr) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + WIDTH'(1);
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_flag_ctrl.sv
// FIFO flag controller for an external RAM: accepts requests, generates RAM
// enables and addresses, keeps the entry count and registered status flags,
// and pulses the set/clear inputs of a downstream half-full direction flop.
module fifo_flag_ctrl
  import fifo_flag_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned AFULL_LEVEL  = DefAfullLevel,
  parameter int unsigned AEMPTY_LEVEL = DefAemptyLevel
) (
  input  logic             clock,
  input  logic             sclr,
  fifo_flag_ctrl_if.slave  bus
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] DepthC  = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AfullC  = CW'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AemptyC = CW'(AEMPTY_LEVEL);
  localparam logic [ADDR_WIDTH:0] OneC    = CW'(1);

  logic                wr_en;
  logic                rd_en;
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH:0] count_d;
  logic                full_q;
  logic                empty_q;
  logic                afull_q;
  logic                aempty_q;
  logic                dir_set_q;
  logic                dir_clr_q;
  dir_evt_e            dir_evt;
  logic                unused_ptr_msb;

  // Registered flags gate the requests, so a full/empty FIFO never falls through
  assign wr_en = bus.wr_req & ~full_q;
  assign rd_en = bus.rd_req & ~empty_q;

  fifo_ptr #(
    .WIDTH (CW)
  ) u_wr_ptr (
    .clock (clock),
    .sclr  (sclr),
    .inc   (wr_en),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(
    .WIDTH (CW)
  ) u_rd_ptr (
    .clock (clock),
    .sclr  (sclr),
    .inc   (rd_en),
    .ptr   (rd_ptr)
  );

  // Pointer wrap bit is kept for form but only the address bits leave the block
  assign unused_ptr_msb = wr_ptr[ADDR_WIDTH] ^ rd_ptr[ADDR_WIDTH];

  // Next count: up on write-only, down on read-only, otherwise hold
  always_comb begin
    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + OneC;
      2'b01:   count_d = count_q - OneC;
      default: count_d = count_q;
    endcase
  end

  // Classify this cycle's count change against the half-full boundary
  always_comb begin
    dir_evt = dir_event(32'(count_q), 32'(count_d), DEPTH);
  end

  // Count, status flags and direction pulses, all reflecting post-edge state
  always_ff @(posedge clock) begin
    if (sclr) begin
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      dir_set_q <= 1'b0;
      dir_clr_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      full_q    <= (count_d == DepthC);
      empty_q   <= (count_d == '0);
      afull_q   <= (count_d >= AfullC);
      aempty_q  <= (count_d <= AemptyC);
      dir_set_q <= (dir_evt == DirSet);
      dir_clr_q <= (dir_evt == DirClr);
    end
  end

  assign bus.wr_en        = wr_en;
  assign bus.rd_en        = rd_en;
  assign bus.wr_adr       = wr_ptr[ADDR_WIDTH-1:0];
  assign bus.rd_adr       = rd_ptr[ADDR_WIDTH-1:0];
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.dir_set      = dir_set_q;
  assign bus.dir_clr      = dir_clr_q;

endmodule
